// File: rtl/clk_enable_scheduler.sv
// clk_enable_scheduler: three independent programmable clock-enable channels.
// Latency: tick/clk_sq are registered; a config update lands on the next wrap
// edge, or on the edge after acceptance when the channel is disabled.
// Backpressure: cfg_ready drops for a channel while it holds a pending update;
// channel 3 is a sink that always accepts and discards.
//
// Ports:
//   basys_clk        single clock domain (100 MHz board clock)
//   reset_n          asynchronous active-low reset
//   cfg_valid/ready  config handshake; transfer on cfg_valid & cfg_ready
//   cfg_ch           target channel 0..2, 3 = null sink
//   cfg_div          new divisor (0 and 1 are clamped to 2)
//   cfg_en           new channel enable
//   tick[2:0]        one-cycle enable pulse per channel, every div cycles
//   clk_sq[2:0]      square wave per channel, period 2*div cycles
//   busy[2:0]        update pending per channel
module clk_enable_scheduler #(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned DEF_DIV0 = 8,
  parameter int unsigned DEF_DIV1 = 2500,
  parameter int unsigned DEF_DIV2 = 50000000
) (
  input  logic             basys_clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic [2:0]       tick,
  output logic [2:0]       clk_sq,
  output logic [2:0]       busy
);

  localparam logic [CNT_W-1:0] DEF_DIV [3] = '{CNT_W'(DEF_DIV0), CNT_W'(DEF_DIV1), CNT_W'(DEF_DIV2)};

  logic [CNT_W-1:0] cnt_q      [3];
  logic [CNT_W-1:0] cnt_d      [3];
  logic [CNT_W-1:0] div_act_q  [3];
  logic [CNT_W-1:0] div_act_d  [3];
  logic [CNT_W-1:0] div_pend_q [3];
  logic [CNT_W-1:0] div_pend_d [3];
  logic [2:0]       en_act_q,  en_act_d;
  logic [2:0]       en_pend_q, en_pend_d;
  logic [2:0]       pend_q,    pend_d;
  logic [2:0]       sq_q,      sq_d;
  logic [2:0]       tick_q,    tick_d;
  logic [2:0]       wrap;
  logic [3:0]       pend_ext;
  logic [CNT_W-1:0] div_clamped;
  logic             xfer;

  // Channel 3 maps onto a constant-zero pending bit so the sink is always ready.
  assign pend_ext    = {1'b0, pend_q};
  assign cfg_ready   = ~pend_ext[cfg_ch];
  assign xfer        = cfg_valid & cfg_ready;
  assign div_clamped = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wrap[i]       = en_act_q[i] && (cnt_q[i] == div_act_q[i] - CNT_W'(1));
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      div_pend_d[i] = div_pend_q[i];
      en_act_d[i]   = en_act_q[i];
      en_pend_d[i]  = en_pend_q[i];
      pend_d[i]     = pend_q[i];
      sq_d[i]       = sq_q[i];
      tick_d[i]     = 1'b0;

      if (en_act_q[i]) begin
        if (wrap[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
          // Updates only land on a period boundary; the wrap tick still fires.
          // Only an update pending before this edge applies here, so an accept
          // coinciding with the wrap waits a full old period.
          if (pend_q[i]) begin
            div_act_d[i] = div_pend_q[i];
            en_act_d[i]  = en_pend_q[i];
            pend_d[i]    = 1'b0;
            if (!en_pend_q[i]) sq_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        // A stopped channel has no period boundary to wait for.
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        if (pend_q[i]) begin
          div_act_d[i] = div_pend_q[i];
          en_act_d[i]  = en_pend_q[i];
          pend_d[i]    = 1'b0;
        end
      end

      // cfg_ready guarantees pend_q is clear here, so this never races an apply.
      if (xfer && (cfg_ch == 2'(i))) begin
        pend_d[i]     = 1'b1;
        div_pend_d[i] = div_clamped;
        en_pend_d[i]  = cfg_en;
      end
    end
  end

  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= DEF_DIV[i];
        div_pend_q[i] <= DEF_DIV[i];
      end
      en_act_q  <= 3'b111;
      en_pend_q <= 3'b111;
      pend_q    <= 3'b000;
      sq_q      <= 3'b000;
      tick_q    <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_act_q[i]  <= div_act_d[i];
        div_pend_q[i] <= div_pend_d[i];
      end
      en_act_q  <= en_act_d;
      en_pend_q <= en_pend_d;
      pend_q    <= pend_d;
      sq_q      <= sq_d;
      tick_q    <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign clk_sq = sq_q;
  assign busy   = pend_q;

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Testbench for clk_enable_scheduler: directed scenarios with literal tick
// timestamps plus randomized config traffic, all checked every cycle against
// a timestamp-based reference model (absolute edge number of each next wrap).
module tb_clk_enable_scheduler;
  localparam int CNT_W = 26;
  localparam int DEF [3] = '{8, 2500, 50000000};

  logic             basys_clk = 1'b0;
  logic             reset_n;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = 2'd0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_en = 1'b0;
  logic [2:0]       tick, clk_sq, busy;

  clk_enable_scheduler #(.CNT_W(CNT_W)) dut (
    .basys_clk(basys_clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_en(cfg_en),
    .tick(tick), .clk_sq(clk_sq), .busy(busy)
  );

  always #5 basys_clk = ~basys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: n = rising edges since reset release; each channel keeps
  // the absolute edge number of its next wrap instead of a counter.
  longint n;
  longint m_next [3];
  longint m_per  [3];
  bit     m_en   [3];
  bit     m_sq   [3];
  bit     m_tick [3];
  bit     m_pend [3];
  bit     m_pen  [3];
  longint m_pdiv [3];

  function automatic bit m_ready(input int ch);
    return (ch == 3) ? 1'b1 : !m_pend[ch];
  endfunction

  always @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0;
      for (int c = 0; c < 3; c++) begin
        m_per[c] = DEF[c]; m_next[c] = DEF[c]; m_en[c] = 1; m_sq[c] = 0;
        m_tick[c] = 0; m_pend[c] = 0; m_pen[c] = 1; m_pdiv[c] = DEF[c];
      end
    end else begin
      bit acc;
      acc = cfg_valid && m_ready(int'(cfg_ch));
      n++;
      for (int c = 0; c < 3; c++) begin
        m_tick[c] = 0;
        if (m_en[c]) begin
          if (n == m_next[c]) begin
            m_tick[c] = 1;
            m_sq[c] = !m_sq[c];
            if (m_pend[c]) begin
              m_per[c] = m_pdiv[c]; m_en[c] = m_pen[c]; m_pend[c] = 0;
              if (!m_pen[c]) m_sq[c] = 0;
            end
            m_next[c] = n + m_per[c];
          end
        end else begin
          m_sq[c] = 0;
          if (m_pend[c]) begin
            m_per[c] = m_pdiv[c]; m_en[c] = m_pen[c]; m_pend[c] = 0;
            m_next[c] = n + m_per[c];
          end
        end
      end
      if (acc && cfg_ch != 2'd3) begin
        m_pend[cfg_ch] = 1;
        m_pen[cfg_ch]  = cfg_en;
        m_pdiv[cfg_ch] = (cfg_div < 2) ? 2 : longint'(cfg_div);
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge basys_clk) begin
    for (int c = 0; c < 3; c++) begin
      check($sformatf("tick[%0d]", c),   64'(tick[c]),   64'(m_tick[c]));
      check($sformatf("clk_sq[%0d]", c), 64'(clk_sq[c]), 64'(m_sq[c]));
      check($sformatf("busy[%0d]", c),   64'(busy[c]),   64'(m_pend[c]));
    end
    check("cfg_ready", 64'(cfg_ready), 64'(m_ready(int'(cfg_ch))));
  end

  // Advance one cycle; returns just after the falling edge, inputs safe to drive.
  task automatic nxt();
    @(negedge basys_clk);
    #1;
  endtask

  task automatic send(input int ch, input int div, input bit en);
    cfg_ch = 2'(ch); cfg_div = CNT_W'(div); cfg_en = en; cfg_valid = 1'b1;
    nxt();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, output longint at);
    int k = 0;
    nxt();
    while (!tick[ch] && k < 3000) begin nxt(); k++; end
    if (!tick[ch]) check($sformatf("tick%0d_timeout", ch), 0, 1);
    at = n;
  endtask

  task automatic expect_tick(input int ch, input longint exp);
    longint at;
    wait_tick(ch, at);
    check($sformatf("tick%0d_time", ch), 64'(at), 64'(exp));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    nxt(); nxt();
    reset_n = 1'b1;
  endtask

  longint a, b, c, w, base;

  initial begin
    reset_n = 1'b0;
    repeat (3) nxt();
    check("rst_tick", 64'(tick), 0);
    check("rst_clk_sq", 64'(clk_sq), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_cfg_ready", 64'(cfg_ready), 1);
    reset_n = 1'b1;

    // Default rates from reset release.
    expect_tick(0, 8);
    check("sq0_after_first_wrap", 64'(clk_sq[0]), 1);
    expect_tick(0, 16);
    check("sq0_after_second_wrap", 64'(clk_sq[0]), 0);
    check("busy_idle", 64'(busy), 0);
    expect_tick(1, 2500);

    // Retune ch0 mid-period (cnt=3) to div 4.
    do_reset();
    while (n < 3) nxt();
    send(0, 4, 1);
    check("busy0_pending", 64'(busy[0]), 1);
    check("ready0_blocked", 64'(cfg_ready), 0);
    expect_tick(0, 8);
    check("busy0_applied", 64'(busy[0]), 0);
    expect_tick(0, 12);
    expect_tick(0, 16);

    // Disable ch1 at its wrap, then re-enable from the stopped state.
    send(1, 2500, 0);
    expect_tick(1, 2500);
    check("sq1_gated", 64'(clk_sq[1]), 0);
    base = n;
    send(1, 10, 1);
    check("busy1_pending", 64'(busy[1]), 1);
    expect_tick(1, base + 12);

    // Clamp: div=1 on ch0 gives period 2; accept lands away from a wrap.
    while (n % 4 != 0) nxt();
    send(0, 1, 1);
    wait_tick(0, a); wait_tick(0, b); wait_tick(0, c);
    check("clamp_period_ab", 64'(b - a), 2);
    check("clamp_period_bc", 64'(c - b), 2);

    // Null sink.
    cfg_ch = 2'd3; cfg_div = CNT_W'(7); cfg_en = 1'b0; cfg_valid = 1'b1;
    #1 check("sink_ready", 64'(cfg_ready), 1);
    nxt();
    cfg_valid = 1'b0;
    check("sink_no_busy", 64'(busy), 0);

    // Accept on the exact wrap edge: old period repeats once.
    wait_tick(0, a);
    nxt();
    send(0, 6, 1);
    w = n;
    check("accept_on_wrap_tick", 64'(tick[0]), 1);
    expect_tick(0, w + 2);
    expect_tick(0, w + 8);
    expect_tick(0, w + 14);

    // Reset while ch2 has a pending update.
    send(2, 5, 1);
    check("busy2_pending", 64'(busy[2]), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_tick", 64'(tick), 0);
    check("async_rst_clk_sq", 64'(clk_sq), 0);
    check("async_rst_busy", 64'(busy), 0);
    nxt(); nxt();
    reset_n = 1'b1;
    check("post_rst_busy", 64'(busy), 0);
    expect_tick(0, 8);
    expect_tick(1, 2500);

    // Randomized config traffic, model-checked every cycle.
    for (int i = 0; i < 8000; i++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = CNT_W'($urandom_range(0, 12));
      cfg_en    = ($urandom_range(0, 4) != 0);
      if (i == 4000) begin
        cfg_valid = 1'b0;
        do_reset();
      end else begin
        nxt();
      end
    end
    cfg_valid = 1'b0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
